// File: rtl/t05_bitstream_arbiter.sv
// Two-source serial bit arbiter: grants header or codeword producer, packs bits
// MSB-first into bytes, buffers them in a small FIFO and drains to SPI.
module t05_bitstream_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 24
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             hdr_enable,
    input  logic             hdr_bit,
    input  logic             hdr_finish,
    input  logic             cw_enable,
    input  logic             cw_bit,
    input  logic             cw_finish,
    input  logic             flush,
    input  logic             spi_ready,
    output logic             spi_valid,
    output logic [7:0]       spi_byte,
    output logic [1:0]       owner,
    output logic [2:0]       last_bits,
    output logic [CNT_W-1:0] bits_written,
    output logic             err_collision,
    output logic             err_overflow,
    output logic             done
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CW,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            hdr_fin_q;
    logic            cw_fin_q;
    logic            flush_pend;
    logic [7:0]      sr;
    logic [2:0]      bit_cnt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic            acc;
    logic            acc_bit;
    logic            coll;
    logic            flush_go;
    logic            push;
    logic [7:0]      push_data;
    logic            pop;
    logic            full;
    logic            fifo_empty;
    logic            push_ok;
    logic            ovf;
    logic [PW-1:0]   wr_next;
    logic [PW-1:0]   rd_next;
    logic [7:0]      head_next;
    logic            hdr_rise;
    logic            cw_rise;

    // owner code for a given state
    function automatic logic [1:0] owner_of(input state_t s);
        case (s)
            S_IDLE:  owner_of = 2'b00;
            S_HDR:   owner_of = 2'b01;
            S_CW:    owner_of = 2'b10;
            default: owner_of = 2'b11;
        endcase
    endfunction

    assign hdr_rise = hdr_finish & ~hdr_fin_q;
    assign cw_rise  = cw_finish & ~cw_fin_q;

    // state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // grant / next-state decode and which bit (if any) is accepted this cycle
    always_comb begin
        state_next = state;
        acc        = 1'b0;
        acc_bit    = 1'b0;
        coll       = 1'b0;
        flush_go   = 1'b0;
        case (state)
            S_IDLE: begin
                if (flush || flush_pend) begin
                    state_next = S_FLUSH;
                end else if (hdr_enable) begin
                    acc        = 1'b1;
                    acc_bit    = hdr_bit;
                    coll       = cw_enable;
                    state_next = S_HDR;
                end else if (cw_enable) begin
                    acc        = 1'b1;
                    acc_bit    = cw_bit;
                    state_next = S_CW;
                end
            end
            S_HDR: begin
                acc     = hdr_enable;
                acc_bit = hdr_bit;
                coll    = cw_enable;
                if (hdr_rise) state_next = S_IDLE;
            end
            S_CW: begin
                acc     = cw_enable;
                acc_bit = cw_bit;
                coll    = hdr_enable;
                if (cw_rise) state_next = S_IDLE;
            end
            S_FLUSH: begin
                flush_go   = 1'b1;
                state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // byte assembly, FIFO pointer arithmetic and next head byte
    always_comb begin
        push      = 1'b0;
        push_data = 8'h00;
        if (acc && bit_cnt == 3'd7) begin
            push      = 1'b1;
            push_data = {sr[6:0], acc_bit};
        end else if (flush_go && bit_cnt != 3'd0) begin
            push      = 1'b1;
            push_data = sr << (4'd8 - {1'b0, bit_cnt});
        end
        fifo_empty = (wr_ptr == rd_ptr);
        full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        pop        = spi_valid && spi_ready;
        push_ok    = push && (!full || pop);
        ovf        = push && full && !pop;
        rd_next    = rd_ptr + PW'(pop);
        wr_next    = wr_ptr + PW'(push_ok);
        if (rd_next == wr_next) begin
            head_next = 8'h00;
        end else if (rd_next == wr_ptr) begin
            head_next = push_data;
        end else begin
            head_next = mem[rd_next[PTR_W-1:0]];
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    // datapath, counters, flags and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hdr_fin_q     <= 1'b0;
            cw_fin_q      <= 1'b0;
            flush_pend    <= 1'b0;
            sr            <= 8'h00;
            bit_cnt       <= 3'd0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            spi_valid     <= 1'b0;
            spi_byte      <= 8'h00;
            owner         <= 2'b00;
            last_bits     <= 3'd0;
            bits_written  <= '0;
            err_collision <= 1'b0;
            err_overflow  <= 1'b0;
            done          <= 1'b0;
        end else begin
            hdr_fin_q <= hdr_finish;
            cw_fin_q  <= cw_finish;
            if (state == S_FLUSH) begin
                flush_pend <= 1'b0;
            end else if (flush && (state == S_HDR || state == S_CW)) begin
                flush_pend <= 1'b1;
            end
            if (acc) begin
                sr      <= {sr[6:0], acc_bit};
                bit_cnt <= bit_cnt + 3'd1;
                if (bits_written != '1) bits_written <= bits_written + CNT_W'(1);
            end
            if (flush_go) begin
                sr        <= 8'h00;
                bit_cnt   <= 3'd0;
                last_bits <= bit_cnt;
            end
            wr_ptr        <= wr_next;
            rd_ptr        <= rd_next;
            spi_valid     <= (rd_next != wr_next);
            spi_byte      <= head_next;
            owner         <= owner_of(state_next);
            done          <= (state_next == S_DONE);
            err_collision <= err_collision | coll;
            err_overflow  <= err_overflow | ovf;
        end
    end

endmodule

// File: tb/tb_t05_bitstream_arbiter.sv
// Scoreboard bench for t05_bitstream_arbiter: a bit-packing model queues the
// bytes each stimulus should produce; a negedge monitor pops and compares them
// as the SPI handshake completes.
module tb_t05_bitstream_arbiter;

    localparam int unsigned CNT_W = 24;

    logic             clk = 1'b0;
    logic             nrst;
    logic             hdr_enable;
    logic             hdr_bit;
    logic             hdr_finish;
    logic             cw_enable;
    logic             cw_bit;
    logic             cw_finish;
    logic             flush;
    logic             spi_ready;
    logic             spi_valid;
    logic [7:0]       spi_byte;
    logic [1:0]       owner;
    logic [2:0]       last_bits;
    logic [CNT_W-1:0] bits_written;
    logic             err_collision;
    logic             err_overflow;
    logic             done;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mdl_sr;
    int         mdl_cnt;
    int         mdl_bits;
    logic [7:0] mon_exp;
    logic [7:0] held;

    t05_bitstream_arbiter #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .hdr_enable    (hdr_enable),
        .hdr_bit       (hdr_bit),
        .hdr_finish    (hdr_finish),
        .cw_enable     (cw_enable),
        .cw_bit        (cw_bit),
        .cw_finish     (cw_finish),
        .flush         (flush),
        .spi_ready     (spi_ready),
        .spi_valid     (spi_valid),
        .spi_byte      (spi_byte),
        .owner         (owner),
        .last_bits     (last_bits),
        .bits_written  (bits_written),
        .err_collision (err_collision),
        .err_overflow  (err_overflow),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_bit(input logic b, input bit drop);
        mdl_sr = {mdl_sr[6:0], b};
        mdl_cnt++;
        mdl_bits++;
        if (mdl_cnt == 8) begin
            if (!drop) exp_q.push_back(mdl_sr);
            mdl_cnt = 0;
        end
    endtask

    task automatic send_bit(input bit cw, input logic b, input bit drop);
        if (cw) begin
            cw_enable = 1'b1;
            cw_bit    = b;
        end else begin
            hdr_enable = 1'b1;
            hdr_bit    = b;
        end
        mdl_bit(b, drop);
        tick();
        hdr_enable = 1'b0;
        cw_enable  = 1'b0;
    endtask

    task automatic pulse_finish(input bit cw);
        if (cw) cw_finish = 1'b1;
        else    hdr_finish = 1'b1;
        tick();
        cw_finish  = 1'b0;
        hdr_finish = 1'b0;
    endtask

    task automatic do_reset();
        nrst       = 1'b0;
        hdr_enable = 1'b0;
        hdr_bit    = 1'b0;
        hdr_finish = 1'b0;
        cw_enable  = 1'b0;
        cw_bit     = 1'b0;
        cw_finish  = 1'b0;
        flush      = 1'b0;
        spi_ready  = 1'b0;
        exp_q.delete();
        mdl_sr   = 8'h00;
        mdl_cnt  = 0;
        mdl_bits = 0;
        tick();
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_eq({pfx, "_spi_valid"}, 32'(spi_valid), 0);
        check_eq({pfx, "_spi_byte"}, 32'(spi_byte), 0);
        check_eq({pfx, "_owner"}, 32'(owner), 0);
        check_eq({pfx, "_last_bits"}, 32'(last_bits), 0);
        check_eq({pfx, "_bits_written"}, 32'(bits_written), 0);
        check_eq({pfx, "_err_coll"}, 32'(err_collision), 0);
        check_eq({pfx, "_err_ovf"}, 32'(err_overflow), 0);
        check_eq({pfx, "_done"}, 32'(done), 0);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && spi_valid; i++) tick();
        check_eq(tag, 32'(spi_valid), 0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check_eq(tag, 32'(done), 1);
    endtask

    // scoreboard: compare each byte as the handshake completes
    always @(negedge clk) begin
        if (nrst && spi_valid && spi_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spi_unexpected_pop", 32'(spi_valid), 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("spi_byte", 32'(spi_byte), 32'(mon_exp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] t1_bits;
        logic [7:0] pad;
        t1_bits = 9'b1_0100_0011;

        // reset state
        do_reset();
        check_zero_outputs("rst");

        // header burst of 9 bits, byte appears one cycle after the 8th bit
        spi_ready = 1'b1;
        for (int i = 8; i >= 1; i--) begin
            send_bit(1'b0, t1_bits[i], 1'b0);
            if (i == 8) check_eq("t1_owner_hdr", 32'(owner), 1);
        end
        check_eq("t1_valid", 32'(spi_valid), 1);
        check_eq("t1_byte_a1", 32'(spi_byte), 32'h A1);
        send_bit(1'b0, t1_bits[0], 1'b0);
        pulse_finish(1'b0);
        check_eq("t1_owner_idle", 32'(owner), 0);
        check_eq("t1_bits_written", 32'(bits_written), 9);

        // tie in IDLE: header wins, codeword bit dropped with collision
        hdr_enable = 1'b1;
        hdr_bit    = 1'b0;
        cw_enable  = 1'b1;
        cw_bit     = 1'b1;
        mdl_bit(1'b0, 1'b0);
        tick();
        hdr_enable = 1'b0;
        cw_enable  = 1'b0;
        check_eq("t2_owner_hdr", 32'(owner), 1);
        check_eq("t2_err_coll", 32'(err_collision), 1);
        check_eq("t2_bits_written", 32'(bits_written), 32'(mdl_bits));
        pulse_finish(1'b0);
        check_eq("t2_owner_idle", 32'(owner), 0);
        send_bit(1'b1, 1'b1, 1'b0);
        check_eq("t2_owner_cw", 32'(owner), 2);
        while (mdl_cnt != 0) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        wait_drain("t2_drain", 20);

        // overflow with SPI stalled: 4 bytes held, 5th dropped
        spi_ready = 1'b0;
        for (int i = 0; i < 40; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), (i / 8) == 4);
        check_eq("t3_err_ovf", 32'(err_overflow), 1);
        check_eq("t3_valid", 32'(spi_valid), 1);
        check_eq("t3_head", 32'(spi_byte), 32'(exp_q[0]));
        held = spi_byte;
        tick();
        tick();
        tick();
        check_eq("t3_head_stable", 32'(spi_byte), 32'(held));
        check_eq("t3_bits_written", 32'(bits_written), 32'(mdl_bits));
        spi_ready = 1'b1;
        wait_drain("t3_drain", 20);

        // trailing partial byte 1,1,0 padded on flush
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        pulse_finish(1'b1);
        pad = mdl_sr << (8 - mdl_cnt);
        check_eq("t4_pad_model", 32'(pad), 32'h C0);
        exp_q.push_back(pad);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("t4_done", 12);
        check_eq("t4_last_bits", 32'(last_bits), 3);
        check_eq("t4_owner_flush", 32'(owner), 3);
        check_eq("t4_q_empty", 32'(exp_q.size()), 0);

        // flush on a byte boundary with an empty FIFO
        do_reset();
        spi_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("t5_done", 4);
        check_eq("t5_last_bits", 32'(last_bits), 0);
        check_eq("t5_valid", 32'(spi_valid), 0);
        hdr_enable = 1'b1;
        cw_enable  = 1'b1;
        tick();
        hdr_enable = 1'b0;
        cw_enable  = 1'b0;
        check_eq("t5_ignored_bits", 32'(bits_written), 0);
        check_eq("t5_ignored_coll", 32'(err_collision), 0);
        check_eq("t5_done_held", 32'(done), 1);

        // reset mid-byte with 2 bytes queued
        do_reset();
        for (int i = 0; i < 21; i++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        check_eq("t6_valid_before", 32'(spi_valid), 1);
        check_eq("t6_bits_before", 32'(bits_written), 21);
        nrst = 1'b0;
        #1;
        check_zero_outputs("t6_rst");
        exp_q.delete();
        mdl_sr   = 8'h00;
        mdl_cnt  = 0;
        mdl_bits = 0;
        tick();
        nrst      = 1'b1;
        spi_ready = 1'b1;
        tick();
        begin
            logic [7:0] pat;
            pat = 8'h5C;
            for (int i = 7; i >= 0; i--) send_bit(1'b0, pat[i], 1'b0);
        end
        check_eq("t6_byte_5c", 32'(spi_byte), 32'h 5C);
        check_eq("t6_owner", 32'(owner), 1);
        check_eq("t6_bits_written", 32'(bits_written), 8);
        wait_drain("t6_drain", 10);
        check_eq("t6_q_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
